irq_pending_ctrl: RTL and testbench

- Interrupt capture-and-deliver controller for the RV32 core with FPU.
- Latches interrupt events from peripherals and the FPU into a pending register.
- Arbitrates among enabled pending interrupts and presents one request at a time to the CPU trap logic with a req/ack handshake.
- Tracks the in-service window until the return-from-trap (int_done).

---
 rtl/irq_pending_ctrl_if.sv | 25 ++
 rtl/irq_pending_ctrl.sv | 112 +++++++++++
 tb/tb_irq_pending_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_pending_ctrl_if.sv
// Interrupt controller bus: peripheral events and enables in, req/ack/done
// handshake to the CPU trap logic, plus pending readback for CSRs.
interface irq_pending_ctrl_if #(
    parameter int NIRQ    = 4,
    parameter int CAUSE_W = 2
);
    logic [NIRQ-1:0]    irq_in;
    logic [NIRQ-1:0]    irq_en;
    logic               int_ack;
    logic               int_done;
    logic               int_req;
    logic [CAUSE_W-1:0] int_cause;
    logic               in_service;
    logic [NIRQ-1:0]    pending;

    modport master (
        output irq_in, irq_en, int_ack, int_done,
        input  int_req, int_cause, in_service, pending
    );

    modport slave (
        input  irq_in, irq_en, int_ack, int_done,
        output int_req, int_cause, in_service, pending
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt capture-and-deliver controller: latches events into a pending register,
// presents the lowest-index enabled one via req/ack, tracks service until done.
// Build option IRQ_LEVEL_EN: level mode (pending follows irq_in, ack does not clear).
module irq_pending_ctrl #(
    parameter int NIRQ    = 4,
    parameter int CAUSE_W = 2
) (
    input  logic                 clk,
    input  logic                 clrn,
    irq_pending_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NIRQ-1:0]    r_pending;
    logic               r_int_req;
    logic [CAUSE_W-1:0] r_int_cause;
    logic               r_in_service;

    logic [NIRQ-1:0]    w_masked;
    logic [CAUSE_W-1:0] w_win_idx;
    logic               w_ack_take;

    assign w_masked   = r_pending & bus.irq_en;
    assign w_ack_take = (r_state == ST_REQ) && bus.int_ack;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        w_win_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_win_idx = CAUSE_W'(i);
            end
        end
    end

`ifdef IRQ_LEVEL_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pending <= '0;
        end else begin
            r_pending <= bus.irq_in;
        end
    end
`else
    logic [NIRQ-1:0] r_irq_dly;
    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_clr_mask;

    assign w_rise     = bus.irq_in & ~r_irq_dly;
    assign w_clr_mask = w_ack_take ? (NIRQ'(1) << r_int_cause) : '0;

    // Set is OR-ed in after the clear so a coincident new edge is never lost.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_irq_dly <= '0;
            r_pending <= '0;
        end else begin
            r_irq_dly <= bus.irq_in;
            r_pending <= (r_pending & ~w_clr_mask) | w_rise;
        end
    end
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_IDLE;
            r_int_req    <= 1'b0;
            r_int_cause  <= '0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_masked) begin
                        r_int_req   <= 1'b1;
                        r_int_cause <= w_win_idx;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack_take) begin
                        r_int_req    <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (bus.int_done) begin
                        r_in_service <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_int_req    <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_req    = r_int_req;
    assign bus.int_cause  = r_int_cause;
    assign bus.in_service = r_in_service;
    assign bus.pending    = r_pending;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl (edge mode): expectations are queued per step
// and popped against the DUT outputs one time unit after each rising edge.
module tb_irq_pending_ctrl;

    localparam int NIRQ    = 4;
    localparam int CAUSE_W = 2;

    localparam int SEL_REQ   = 0;
    localparam int SEL_CAUSE = 1;
    localparam int SEL_SVC   = 2;
    localparam int SEL_PEND  = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic clrn;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    irq_pending_ctrl_if #(.NIRQ(NIRQ), .CAUSE_W(CAUSE_W)) bus ();

    irq_pending_ctrl #(.NIRQ(NIRQ), .CAUSE_W(CAUSE_W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_REQ:   return 32'(bus.int_req);
            SEL_CAUSE: return 32'(bus.int_cause);
            SEL_SVC:   return 32'(bus.in_service);
            default:   return 32'(bus.pending);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
            $display("t=%0t %s observed=%0h expected=%0h", $time, e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clrn         = 1'b0;
        bus.irq_in   = '0;
        bus.irq_en   = '0;
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;

        // Reset state
        #12;
        expect_val("rst_req", SEL_REQ, 0);
        expect_val("rst_cause", SEL_CAUSE, 0);
        expect_val("rst_svc", SEL_SVC, 0);
        expect_val("rst_pend", SEL_PEND, 0);
        check_all();
        clrn = 1'b1;
        tick();

        // Single event on source 2
        bus.irq_en = 4'b1111;
        bus.irq_in = 4'b0100;
        expect_val("single_pend_e0", SEL_PEND, 4'b0100);
        expect_val("single_req_e0", SEL_REQ, 0);
        tick();
        bus.irq_in = 4'b0000;
        expect_val("single_req_e1", SEL_REQ, 1);
        expect_val("single_cause_e1", SEL_CAUSE, 2);
        tick();
        bus.int_ack = 1'b1;
        expect_val("single_ack_pend", SEL_PEND, 0);
        expect_val("single_ack_svc", SEL_SVC, 1);
        expect_val("single_ack_req", SEL_REQ, 0);
        tick();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        expect_val("single_done_svc", SEL_SVC, 0);
        expect_val("single_done_req", SEL_REQ, 0);
        tick();
        bus.int_done = 1'b0;
        expect_val("single_idle_req", SEL_REQ, 0);
        tick();

        // Priority and stability
        bus.irq_in = 4'b1000;
        expect_val("prio_pend3", SEL_PEND, 4'b1000);
        tick();
        bus.irq_in = 4'b0000;
        expect_val("prio_req3", SEL_REQ, 1);
        expect_val("prio_cause3", SEL_CAUSE, 3);
        tick();
        bus.irq_in = 4'b0001;
        expect_val("prio_pend9", SEL_PEND, 4'b1001);
        expect_val("prio_hold_cause", SEL_CAUSE, 3);
        expect_val("prio_hold_req", SEL_REQ, 1);
        tick();
        bus.irq_in = 4'b0000;
        expect_val("prio_hold_cause2", SEL_CAUSE, 3);
        tick();
        bus.int_ack = 1'b1;
        expect_val("prio_ack_pend", SEL_PEND, 4'b0001);
        expect_val("prio_ack_svc", SEL_SVC, 1);
        tick();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        expect_val("prio_done_svc", SEL_SVC, 0);
        expect_val("prio_done_req", SEL_REQ, 0);
        tick();
        bus.int_done = 1'b0;
        expect_val("prio_next_req", SEL_REQ, 1);
        expect_val("prio_next_cause", SEL_CAUSE, 0);
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;
        expect_val("prio_clean_pend", SEL_PEND, 0);
        tick();

        // Masking
        bus.irq_en = 4'b0000;
        bus.irq_in = 4'b0010;
        expect_val("mask_pend", SEL_PEND, 4'b0010);
        tick();
        bus.irq_in = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            expect_val("mask_req_low", SEL_REQ, 0);
            tick();
        end
        bus.irq_en = 4'b0010;
        expect_val("mask_en_req", SEL_REQ, 1);
        expect_val("mask_en_cause", SEL_CAUSE, 1);
        tick();

        // Set/clear collision on source 1
        bus.int_ack = 1'b1;
        bus.irq_in  = 4'b0010;
        expect_val("coll_pend", SEL_PEND, 4'b0010);
        expect_val("coll_svc", SEL_SVC, 1);
        tick();
        bus.int_ack  = 1'b0;
        bus.irq_in   = 4'b0000;
        bus.int_done = 1'b1;
        expect_val("coll_done_svc", SEL_SVC, 0);
        tick();
        bus.int_done = 1'b0;
        expect_val("coll_rereq", SEL_REQ, 1);
        expect_val("coll_recause", SEL_CAUSE, 1);
        tick();
        bus.int_ack = 1'b1;
        expect_val("coll_ack_pend", SEL_PEND, 0);
        tick();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;

        // Held source 0: one event only
        bus.irq_en = 4'b1111;
        bus.irq_in = 4'b0001;
        expect_val("held_pend", SEL_PEND, 4'b0001);
        tick();
        expect_val("held_req", SEL_REQ, 1);
        expect_val("held_cause", SEL_CAUSE, 0);
        tick();
        bus.int_ack = 1'b1;
        expect_val("held_ack_pend", SEL_PEND, 0);
        tick();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        expect_val("held_done_svc", SEL_SVC, 0);
        tick();
        bus.int_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            expect_val("held_no_req", SEL_REQ, 0);
            expect_val("held_no_pend", SEL_PEND, 0);
            tick();
        end
        bus.irq_in = 4'b0000;
        tick();
        bus.irq_in = 4'b0001;
        expect_val("held_repend", SEL_PEND, 4'b0001);
        tick();
        bus.irq_in = 4'b0000;
        expect_val("held_rereq", SEL_REQ, 1);
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        tick();
        bus.int_done = 1'b0;

        // Asynchronous reset mid-REQ
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = 4'b1000;
        expect_val("arst_pre_req", SEL_REQ, 1);
        expect_val("arst_pre_cause", SEL_CAUSE, 2);
        tick();
        bus.irq_in = 4'b0000;
        expect_val("arst_pre_pend", SEL_PEND, 4'b1100);
        check_all();
        #2;
        clrn = 1'b0;
        #1;
        expect_val("arst_req", SEL_REQ, 0);
        expect_val("arst_pend", SEL_PEND, 0);
        expect_val("arst_svc", SEL_SVC, 0);
        expect_val("arst_cause", SEL_CAUSE, 0);
        check_all();
        #10;
        clrn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
